// File: rtl/ps2_keyboard_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx_if
//  Purpose  : Key-event bus from the PS/2 receiver to the game-control logic.
//             The receiver drives it through the master modport and the
//             consumer reads it through the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_keyboard_rx_if;
  logic [7:0] key_code;     // last non-prefix scan code byte
  logic       key_ext;      // E0 prefix preceded key_code
  logic       key_release;  // F0 prefix preceded key_code
  logic       key_valid;    // one-cycle event strobe
  logic       rx_error;     // one-cycle frame error strobe
  logic       busy;         // frame in progress

  modport master (
    output key_code,
    output key_ext,
    output key_release,
    output key_valid,
    output rx_error,
    output busy
  );

  modport slave (
    input key_code,
    input key_ext,
    input key_release,
    input key_valid,
    input rx_error,
    input busy
  );
endinterface
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx
//  Purpose  : PS/2 keyboard receiver. Synchronizes and deglitches the PS/2
//             pins, deserializes 11-bit device-to-host frames, checks start,
//             odd parity and stop bits, folds E0/F0 prefixes into flags and
//             emits one key event per make/break code.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,       // 2..15 stable samples per clk edge
  parameter int TIMEOUT_CYCLES = 100000   // idle clk cycles tolerated mid-frame
) (
  input  wire                       clk,
  input  wire                       sys_nrst,
  input  wire                       ps2_clk,
  input  wire                       ps2_data,
  ps2_keyboard_rx_if.master         key_bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int         c_to_w     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] c_filt_last = 4'(FILTER_LEN - 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_code_ext = 8'hE0;
  localparam logic [7:0] c_code_rel = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Pin conditioning state
  // --------------------------------------------------------------------------
  logic       r_clk_s1;
  logic       r_clk_s2;
  logic       r_dat_s1;
  logic       r_dat_s2;
  logic       r_filt_clk;
  logic       r_filt_d;
  logic [3:0] r_filt_cnt;
  logic       r_strobe;

  // --------------------------------------------------------------------------
  // Frame and decoder state
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_sh;
  logic              r_perr;
  logic [c_to_w-1:0] r_to_cnt;
  logic              r_ext_pend;
  logic              r_rel_pend;
  logic [7:0]        r_key_code;
  logic              r_key_ext;
  logic              r_key_release;
  logic              r_key_valid;
  logic              r_rx_error;

  logic              w_bit;
  logic              w_fall;

  // The data bit is taken from the synchronized data line in the strobe cycle.
  assign w_bit  = r_dat_s2;
  // Filtered clock was high last cycle and is low now.
  assign w_fall = r_filt_d & ~r_filt_clk;

  // Two-flop synchronizers for both pins; idle level is high.
  always_ff @(posedge clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock deglitch: follow the synchronized clock only after it has disagreed
  // with the filtered value for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= 4'd0;
    end else if (r_clk_s2 != r_filt_clk) begin
      if (r_filt_cnt == c_filt_last) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= 4'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end
    end else begin
      r_filt_cnt <= 4'd0;
    end
  end

  // Edge register: one-cycle strobe in the cycle after the filtered clock falls.
  always_ff @(posedge clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_filt_d <= 1'b1;
      r_strobe <= 1'b0;
    end else begin
      r_filt_d <= r_filt_clk;
      r_strobe <= w_fall;
    end
  end

  // Frame FSM with timeout, prefix folding and registered event outputs.
  // A strobe takes priority over the timeout terminal count in the same cycle.
  always_ff @(posedge clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_sh          <= 8'd0;
      r_perr        <= 1'b0;
      r_to_cnt      <= '0;
      r_ext_pend    <= 1'b0;
      r_rel_pend    <= 1'b0;
      r_key_code    <= 8'd0;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
      r_key_valid   <= 1'b0;
      r_rx_error    <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_rx_error  <= 1'b0;

      if (r_strobe) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            // Only a low start bit opens a frame; a high one is noise.
            if (!w_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            r_sh      <= {w_bit, r_sh[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            // Data plus parity must hold an odd number of ones.
            r_perr  <= ~(^r_sh ^ w_bit);
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (w_bit && !r_perr) begin
              if (r_sh == c_code_ext) begin
                r_ext_pend <= 1'b1;
              end else if (r_sh == c_code_rel) begin
                r_rel_pend <= 1'b1;
              end else begin
                r_key_code    <= r_sh;
                r_key_ext     <= r_ext_pend;
                r_key_release <= r_rel_pend;
                r_key_valid   <= 1'b1;
                r_ext_pend    <= 1'b0;
                r_rel_pend    <= 1'b0;
              end
            end else begin
              r_rx_error <= 1'b1;
              r_ext_pend <= 1'b0;
              r_rel_pend <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_to_last) begin
        // Stalled frame: drop the partial byte and report it.
        r_state    <= ST_IDLE;
        r_to_cnt   <= '0;
        r_sh       <= 8'd0;
        r_bit_cnt  <= 3'd0;
        r_rx_error <= 1'b1;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + c_to_w'(1);
      end
    end
  end

  assign key_bus.key_code    = r_key_code;
  assign key_bus.key_ext     = r_key_ext;
  assign key_bus.key_release = r_key_release;
  assign key_bus.key_valid   = r_key_valid;
  assign key_bus.rx_error    = r_rx_error;
  assign key_bus.busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
